// File: rtl/r2r_pkg.sv
// Shared types and constants for R2R ladder blocks.
package r2r_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SLEW,
        SETTLE,
        DONE
    } r2r_state_t;

    localparam logic [15:0] MV_TO_CODE_MULT  = 16'd5066;
    localparam int unsigned MV_TO_CODE_SHIFT = 16;
    localparam logic [7:0]  CODE_MAX         = 8'hFF;

    // Millivolts to ladder code: (mv * 5066) >> 16, saturated to CODE_MAX.
    function automatic logic [7:0] mv_to_code(input logic [15:0] mv);
        logic [31:0] prod;
        logic [31:0] shifted;
        prod    = {16'd0, mv} * {16'd0, MV_TO_CODE_MULT};
        shifted = prod >> MV_TO_CODE_SHIFT;
        if (shifted > {24'd0, CODE_MAX}) begin
            return CODE_MAX;
        end
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/slew_timer.sv
// Terminal-count timer: counts 0..count_max while enabled, then wraps to 0.
module slew_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_max,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    assign tc = enable && (count == count_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/r2r_dac_driver.sv
// Slew-limited R2R ladder driver: converts a millivolt request to a code and ramps the bus to it.
module r2r_dac_driver
    import r2r_pkg::*;
#(
    parameter int unsigned STEP_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] target_mv,
    input  logic        target_valid,
    output logic        target_ready,
    input  logic        abort,
    output logic [7:0]  r2r_bus,
    output logic        busy,
    output logic        done
);

    localparam int unsigned STEP_W   = $clog2(STEP_CYCLES + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    r2r_state_t  state;
    logic [15:0] mv_q;
    logic [7:0]  code;

    logic step_load;
    logic step_en;
    logic step_tc;
    logic settle_load;
    logic settle_en;
    logic settle_tc;

    // Loading on abort clears both counters on the same edge that leaves the state.
    assign step_load   = (state != SLEW) || abort;
    assign step_en     = (state == SLEW) && (r2r_bus != code);
    assign settle_load = (state != SETTLE) || abort;
    assign settle_en   = (state == SETTLE);

    slew_timer #(
        .WIDTH (STEP_W)
    ) u_step_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (step_load),
        .enable    (step_en),
        .count_max (STEP_W'(STEP_CYCLES - 1)),
        .tc        (step_tc)
    );

    slew_timer #(
        .WIDTH (SETTLE_W)
    ) u_settle_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (settle_load),
        .enable    (settle_en),
        .count_max (SETTLE_W'(SETTLE_CYCLES - 1)),
        .tc        (settle_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mv_q         <= '0;
            code         <= '0;
            r2r_bus      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            target_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (target_valid && target_ready) begin
                        mv_q         <= target_mv;
                        state        <= CONVERT;
                        busy         <= 1'b1;
                        target_ready <= 1'b0;
                    end
                end
                CONVERT: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        target_ready <= 1'b1;
                    end else begin
                        code  <= mv_to_code(mv_q);
                        state <= SLEW;
                    end
                end
                SLEW: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        target_ready <= 1'b1;
                    end else if (r2r_bus == code) begin
                        state <= SETTLE;
                    end else if (step_tc) begin
                        // Moving toward an in-range code can never wrap.
                        r2r_bus <= (r2r_bus < code) ? r2r_bus + 8'd1 : r2r_bus - 8'd1;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        target_ready <= 1'b1;
                    end else if (settle_tc) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    target_ready <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    target_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/r2r_dac_driver.md
R2R_DAC_DRIVER -- requirements
Module: r2r_dac_driver

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 1000: clocks per 1-LSB bus step (slew limit).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 100: clocks held after reaching the target code, before done.
REQ-003 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port target_mv  input  16: requested output voltage in millivolts, unsigned.
REQ-006 SHALL have port target_valid  input  1: request strobe.
REQ-007 SHALL have port target_ready  output  1: block accepts a request this cycle.
REQ-008 SHALL have port abort  input  1: synchronous cancel of the request in progress.
REQ-009 SHALL have port r2r_bus  output  8: registered code driving the R2R ladder.
REQ-010 SHALL have port busy  output  1: a request is in progress.
REQ-011 SHALL have port done  output  1: one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, CONVERT, SLEW, SETTLE, DONE.
REQ-013 SHALL drive target_ready=1 only in IDLE; a request is accepted on a cycle where target_valid and target_ready are both 1 (cycle 0), and target_mv is registered on that edge.
REQ-014 SHALL ignore target_valid in all states other than IDLE, with no queuing.
REQ-015 SHALL, in CONVERT (cycle 1), register code = (mv × 5066) >> 16 using a 32-bit product, saturated to 255 when the shifted result exceeds 255.
REQ-016 SHALL, in SLEW, compare r2r_bus with code every cycle; if they are equal, go to SETTLE on the next edge without stepping.
REQ-017 SHALL, in SLEW, run a step counter from 0 to STEP_CYCLES-1, cleared on SLEW entry; at terminal count, r2r_bus moves ±1 toward code and the counter restarts.
REQ-018 SHALL change r2r_bus by at most 1 LSB per step and SHALL never wrap (no 255→0 or 0→255 transition).
REQ-019 SHALL hold SETTLE for exactly SETTLE_CYCLES cycles, then enter DONE.
REQ-020 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL assert done at cycle 3 + |code − r2r_bus_at_accept| × STEP_CYCLES + SETTLE_CYCLES.
REQ-022 SHALL drive busy=1 in CONVERT, SLEW, SETTLE and DONE, and 0 in IDLE.
REQ-023 SHALL, when abort=1 in CONVERT/SLEW/SETTLE, go to IDLE on the next edge: r2r_bus frozen at its current value, no done pulse, step and settle counters cleared.
REQ-024 SHALL ignore abort in IDLE and DONE; done still pulses if DONE is already reached.
REQ-025 SHALL hold r2r_bus constant in IDLE between requests.

Reset
REQ-026 SHALL, on reset assertion, immediately (asynchronously) set state=IDLE, r2r_bus=0, code=0, counters=0, busy=0, done=0 and target_ready=1, including mid-SLEW or mid-SETTLE.
REQ-027 SHALL be able to accept a request on the first rising clk edge after reset deasserts.

Structure
REQ-028 SHALL take from shared package r2r_pkg: the state enum type, MV_TO_CODE_MULT=5066, MV_TO_CODE_SHIFT=16, CODE_MAX=8'hFF.
REQ-029 SHALL implement the step/settle terminal-count counter as sub-module slew_timer (load, enable, terminal-count output), reusable by other R2R blocks.
REQ-030 SHALL register all outputs, with no combinational path from inputs to outputs.

Verification (bench uses STEP_CYCLES=4, SETTLE_CYCLES=3)
REQ-031 SHALL cover reset held, then released -> r2r_bus=0, target_ready=1, busy=0, done=0; assert reset mid-SLEW -> r2r_bus=0 before the next clk edge.
REQ-032 SHALL cover a request of 1000 mV from bus=0 -> code 77, r2r_bus rising monotonically by 1 every 4 cycles, done at cycle 314, final r2r_bus=77.
REQ-033 SHALL cover a request of 5000 mV from bus=77 -> saturates to 255, done at cycle 3+178×4+3=718, r2r_bus never exceeds 255.
REQ-034 SHALL cover a repeated request of 1000 mV while bus=77 -> no bus change, done at cycle 6; a request of 0 mV then ramps down to 0 without wrap.
REQ-035 SHALL cover pulsing target_valid with 2000 mV while busy -> ignored, original target reached; abort mid-SLEW at bus=40 -> IDLE next cycle, r2r_bus holds 40, no done.
